// File: rtl/dm_wait_responder_if.sv
// dm_wait_responder_if: MEM-stage data-memory bus with request/ready handshake and stall.
interface dm_wait_responder_if;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData;
    logic        MemReady;
    logic        MemStall;
    logic        MemErr;
    modport master (
        output MemReq, MemWrite, MemAddr, MemWriteData,
        input  MemReadData, MemReady, MemStall, MemErr
    );
    modport slave (
        input  MemReq, MemWrite, MemAddr, MemWriteData,
        output MemReadData, MemReady, MemStall, MemErr
    );
endinterface

// File: rtl/dm_wait_responder.sv
// dm_wait_responder: data-memory responder with WAIT_CYCLES wait states and MemStall back-pressure.
// Defining DM_INIT_CLEAR_EN adds a post-reset sweep that zero-fills the memory.
module dm_wait_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dm_wait_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
`ifdef DM_INIT_CLEAR_EN
    typedef enum logic [1:0] {IDLE, WAIT, DONE, CLEAR} state_t;
    localparam state_t RST_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam state_t RST_STATE = IDLE;
`endif
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          sel_wr, sel_err, fin, we;
    logic [31:0]   sel_addr, sel_wdata, wval;
    logic [AW-1:0] sel_idx, widx;
`ifdef DM_INIT_CLEAR_EN
    logic [AW-1:0] clr_q, clr_d;
`endif
    always_comb begin
        // IDLE looks at the live bus; once accepted, only the latched copy matters
        sel_wr    = (state_q == IDLE) ? bus.MemWrite     : wr_q;
        sel_addr  = (state_q == IDLE) ? bus.MemAddr      : addr_q;
        sel_wdata = (state_q == IDLE) ? bus.MemWriteData : wdata_q;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= 32'(4 * DEPTH_WORDS));
        sel_idx   = sel_addr[2 +: AW];
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fin       = 1'b0;
`ifdef DM_INIT_CLEAR_EN
        clr_d     = clr_q;
`endif
        case (state_q)
            IDLE: if (bus.MemReq) begin
                wr_d    = bus.MemWrite;
                addr_d  = bus.MemAddr;
                wdata_d = bus.MemWriteData;
                cnt_d   = 4'(WAIT_CYCLES);
                fin     = (WAIT_CYCLES == 0);
                state_d = fin ? DONE : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                fin     = (cnt_q == 4'd1);
                state_d = fin ? DONE : WAIT;
            end
            DONE: state_d = IDLE;
`ifdef DM_INIT_CLEAR_EN
            CLEAR: begin
                clr_d   = clr_q + 1'b1;
                state_d = (clr_q == AW'(DEPTH_WORDS - 1)) ? IDLE : CLEAR;
            end
`endif
            default: state_d = IDLE;
        endcase
        ready_d = fin;
        err_d   = fin && sel_err;
        rdata_d = (fin && !sel_wr && !sel_err) ? mem[sel_idx] : 32'h0;
        // the store commits on the edge that enters DONE; a reset cancels it
        we      = fin && sel_wr && !sel_err && rst_n;
        widx    = sel_idx;
        wval    = sel_wdata;
`ifdef DM_INIT_CLEAR_EN
        if (state_q == CLEAR) begin
            we   = 1'b1;
            widx = clr_q;
            wval = 32'h0;
        end
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef DM_INIT_CLEAR_EN
            clr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
`ifdef DM_INIT_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end
    always_ff @(posedge clk)
        if (we) mem[widx] <= wval;
    assign bus.MemReadData = rdata_q;
    assign bus.MemReady    = ready_q;
    assign bus.MemErr      = err_q;
`ifdef DM_INIT_CLEAR_EN
    assign bus.MemStall = (state_q == IDLE && bus.MemReq) || state_q == WAIT || state_q == CLEAR;
`else
    assign bus.MemStall = (state_q == IDLE && bus.MemReq) || state_q == WAIT;
`endif
endmodule
